// File: rtl/mc_control_unit_if.sv
// ============================================================================
// mc_control_unit_if : control-unit <-> datapath signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mc_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int WAIT_W   = 8
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                alu_done;
  logic                resume;

  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                alu_enable;
  logic                alu_start;
  logic                pc_enable;
  logic                halt;
  logic                fault;
  logic [2:0]          state;
  logic [WAIT_W-1:0]   wait_cnt;

  // master: the control unit, which drives the strobes
  modport master (
    input  opcode, mem_ready, alu_done, resume,
    output reg_write, mem_read, mem_write, alu_enable, alu_start,
           pc_enable, halt, fault, state, wait_cnt
  );

  // slave: the datapath / instruction source
  modport slave (
    output opcode, mem_ready, alu_done, resume,
    input  reg_write, mem_read, mem_write, alu_enable, alu_start,
           pc_enable, halt, fault, state, wait_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mc_control_unit.sv
// ============================================================================
// mc_control_unit : multi-cycle instruction sequencer with memory/ALU waits
// Rev 1.0
// ============================================================================
`default_nettype none

module mc_control_unit #(
  parameter int                  OPCODE_W  = 4,
  parameter logic [OPCODE_W-1:0] OP_LOAD   = 4'b0011,
  parameter logic [OPCODE_W-1:0] OP_STORE  = 4'b0100,
  parameter logic [OPCODE_W-1:0] OP_CRYPTO = 4'b0101,
  parameter logic [OPCODE_W-1:0] OP_HALT   = 4'b1111,
  parameter int                  WAIT_W    = 8,
  parameter int unsigned         TIMEOUT   = 200
) (
  input  wire logic           clk,
  input  wire logic           reset,
  mc_control_unit_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_ALU_WAIT  = 3'd6,
    S_FAULT     = 3'd7
  } state_e;

  localparam bit C_TO_EN = (TIMEOUT != 0);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_hit;

  assign timeout_hit = C_TO_EN && (32'(wait_cnt_q) == TIMEOUT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) state_d = S_MEM;
        else if (bus.opcode == OP_CRYPTO)                    state_d = S_ALU_WAIT;
        else if (bus.opcode == OP_HALT)                      state_d = S_HALT;
        else                                                 state_d = S_WRITEBACK;
      end
      // Completion is tested first so it beats a coincident timeout
      S_MEM: begin
        if (bus.mem_ready)     state_d = S_WRITEBACK;
        else if (timeout_hit)  state_d = S_FAULT;
      end
      S_ALU_WAIT: begin
        if (bus.alu_done)      state_d = S_WRITEBACK;
        else if (timeout_hit)  state_d = S_FAULT;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      if (bus.resume) state_d = S_FETCH;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FETCH;
    endcase

    // Counter restarts on each fresh entry into a wait state and saturates
    wait_cnt_d = '0;
    if ((state_d == S_MEM || state_d == S_ALU_WAIT) && state_d == state_q) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them at once
  always_comb begin
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_enable = 1'b0;
    bus.alu_start  = 1'b0;
    bus.pc_enable  = 1'b0;
    bus.halt       = 1'b0;
    bus.fault      = 1'b0;
    unique case (state_q)
      S_EXECUTE: begin
        bus.alu_enable = 1'b1;
        bus.alu_start  = (bus.opcode == OP_CRYPTO);
      end
      S_MEM: begin
        bus.mem_read  = (bus.opcode == OP_LOAD);
        bus.mem_write = (bus.opcode == OP_STORE);
      end
      S_ALU_WAIT:  bus.alu_enable = 1'b1;
      S_WRITEBACK: begin
        bus.pc_enable = 1'b1;
        bus.reg_write = (bus.opcode != OP_STORE);
      end
      S_HALT: begin
        bus.halt      = 1'b1;
        bus.pc_enable = bus.resume;
      end
      S_FAULT:     bus.fault = 1'b1;
      default:     ;
    endcase
  end

  assign bus.state    = state_q;
  assign bus.wait_cnt = wait_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// ============================================================================
// tb_mc_control_unit : directed self-checking bench for mc_control_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mc_control_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   n_start;
  int   n_start0;

  mc_control_unit_if #(.OPCODE_W(4), .WAIT_W(8)) b1 ();
  mc_control_unit_if #(.OPCODE_W(4), .WAIT_W(2)) b2 ();

  mc_control_unit #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  // Second copy: no timeout, 2-bit counter, fed identical stimulus
  mc_control_unit #(.WAIT_W(2), .TIMEOUT(0)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  assign b2.opcode    = b1.opcode;
  assign b2.mem_ready = b1.mem_ready;
  assign b2.alu_done  = b1.alu_done;
  assign b2.resume    = b1.resume;

  // {reg_write, mem_read, mem_write, alu_enable, alu_start, pc_enable, halt, fault}
  logic [7:0] s1, s2;
  assign s1 = {b1.reg_write, b1.mem_read, b1.mem_write, b1.alu_enable,
               b1.alu_start, b1.pc_enable, b1.halt, b1.fault};
  assign s2 = {b2.reg_write, b2.mem_read, b2.mem_write, b2.alu_enable,
               b2.alu_start, b2.pc_enable, b2.halt, b2.fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial n_start = 0;
  always @(negedge clk) if (b1.alu_start) n_start = n_start + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] sb);
    check_eq({tag, "_state"}, 32'(b1.state), 32'(st));
    check_eq({tag, "_strb"},  32'(s1),       32'(sb));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    b1.opcode = 4'h1;
    b1.mem_ready = 1'b0;
    b1.alu_done = 1'b0;
    b1.resume = 1'b0;
    #3;
    cyc("rst", 3'd0, 8'h00);
    check_eq("rst_wait", 32'(b1.wait_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // plain ALU op: 0,1,2,4,0
    cyc("alu_f", 3'd0, 8'h00);
    step(); cyc("alu_d", 3'd1, 8'h00);
    step(); cyc("alu_e", 3'd2, 8'h10);
    step(); cyc("alu_wb", 3'd4, 8'h84);
    step(); cyc("alu_f2", 3'd0, 8'h00);

    // LOAD, mem_ready high outside MEM must be ignored, ready on 3rd MEM cycle
    b1.opcode = 4'h3;
    b1.mem_ready = 1'b1;
    step(); cyc("ld_d", 3'd1, 8'h00);
    step(); cyc("ld_e", 3'd2, 8'h10);
    step(); b1.mem_ready = 1'b0; b1.alu_done = 1'b1;
    cyc("ld_m0", 3'd3, 8'h40); check_eq("ld_w0", 32'(b1.wait_cnt), 32'd0);
    step(); b1.alu_done = 1'b0;
    cyc("ld_m1", 3'd3, 8'h40); check_eq("ld_w1", 32'(b1.wait_cnt), 32'd1);
    step(); b1.mem_ready = 1'b1;
    cyc("ld_m2", 3'd3, 8'h40); check_eq("ld_w2", 32'(b1.wait_cnt), 32'd2);
    step(); b1.mem_ready = 1'b0;
    cyc("ld_wb", 3'd4, 8'h84); check_eq("ld_wbw", 32'(b1.wait_cnt), 32'd0);
    step(); cyc("ld_f", 3'd0, 8'h00);

    // CRYPTO, done coincides with wait_cnt==TIMEOUT: completion wins
    n_start0 = n_start;
    b1.opcode = 4'h5;
    step(); cyc("cr_d", 3'd1, 8'h00);
    step(); cyc("cr_e", 3'd2, 8'h18);
    for (int i = 0; i < 5; i++) begin
      step();
      cyc("cr_aw", 3'd6, 8'h10);
      check_eq("cr_w", 32'(b1.wait_cnt), 32'(i));
    end
    b1.alu_done = 1'b1;
    step(); b1.alu_done = 1'b0;
    cyc("cr_wb", 3'd4, 8'h84);
    check_eq("cr_pulses", 32'(n_start - n_start0), 32'd1);
    step(); cyc("cr_f", 3'd0, 8'h00);

    // STORE with mem_ready stuck low: 5 MEM cycles then FAULT
    b1.opcode = 4'h4;
    step(); cyc("st_d", 3'd1, 8'h00);
    step(); cyc("st_e", 3'd2, 8'h10);
    for (int i = 0; i < 5; i++) begin
      step();
      cyc("st_m", 3'd3, 8'h20);
      check_eq("st_w", 32'(b1.wait_cnt), 32'(i));
    end
    for (int i = 0; i < 20; i++) begin
      step();
      cyc("st_fault", 3'd7, 8'h01);
    end
    check_eq("sat_state", 32'(b2.state), 32'd3);
    check_eq("sat_wait", 32'(b2.wait_cnt), 32'd3);
    check_eq("sat_strb", 32'(s2), 32'h20);

    // asynchronous reset out of FAULT
    reset = 1'b1;
    #1;
    cyc("flt_rst", 3'd0, 8'h00);
    @(negedge clk) reset = 1'b0;

    // HALT for 10 cycles, resume on the 10th
    b1.opcode = 4'hF;
    step(); cyc("h_d", 3'd1, 8'h00);
    step(); cyc("h_e", 3'd2, 8'h10);
    step();
    for (int i = 0; i < 10; i++) begin
      cyc("h_halt", 3'd5, 8'h02);
      if (i < 9) step();
    end
    b1.resume = 1'b1;
    #1;
    cyc("h_resume", 3'd5, 8'h06);
    step(); b1.resume = 1'b0;
    cyc("h_f", 3'd0, 8'h00);

    // reset between edges on the 2nd MEM cycle
    b1.opcode = 4'h3;
    step(); step(); step();
    step(); cyc("rm_m1", 3'd3, 8'h40);
    check_eq("rm_w1", 32'(b1.wait_cnt), 32'd1);
    #1 reset = 1'b1;
    #1;
    cyc("rm_async", 3'd0, 8'h00);
    check_eq("rm_wait", 32'(b1.wait_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    cyc("rm_rel", 3'd0, 8'h00);
    step(); cyc("rm_d", 3'd1, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter OPCODE_W, default 4, opcode width in bits.
REQ-002 Parameter OP_LOAD, default 4'b0011, load opcode.
REQ-003 Parameter OP_STORE, default 4'b0100, store opcode.
REQ-004 Parameter OP_CRYPTO, default 4'b0101, multi-cycle crypto ALU opcode.
REQ-005 Parameter OP_HALT, default 4'b1111, halt opcode.
REQ-006 Parameter WAIT_W, default 8, wait-counter width.
REQ-007 Parameter TIMEOUT, default 200, maximum wait cycles; 0 disables timeout.
REQ-008 clk  input  1  clock, rising-edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 opcode  input  OPCODE_W  current instruction opcode.
REQ-011 mem_ready  input  1  memory access complete.
REQ-012 alu_done  input  1  crypto ALU operation complete.
REQ-013 resume  input  1  leave HALT.
REQ-014 reg_write, mem_read, mem_write, alu_enable, alu_start, pc_enable, halt, fault  output  1 each  control strobes.
REQ-015 state  output  3  current FSM state.
REQ-016 wait_cnt  output  WAIT_W  cycles spent in the current wait state.

Function
REQ-017 States SHALL be encoded FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, ALU_WAIT=6, FAULT=7.
REQ-018 Strobe outputs SHALL be combinational functions of state, opcode, mem_ready and resume only; each is 0 unless listed for the current state.
REQ-019 opcode SHALL be sampled every cycle; the opcode is stable from DECODE through WRITEBACK.
REQ-020 FETCH SHALL go to DECODE, and DECODE SHALL go to EXECUTE, unconditionally.
REQ-021 EXECUTE: alu_enable=1; OP_LOAD or OP_STORE -> MEM; OP_CRYPTO -> ALU_WAIT with alu_start=1 for this cycle only; OP_HALT -> HALT; any other opcode -> WRITEBACK.
REQ-022 MEM: mem_read=1 for OP_LOAD or mem_write=1 for OP_STORE, held every cycle until mem_ready=1; the mem_ready cycle -> WRITEBACK.
REQ-023 ALU_WAIT: alu_enable=1 each cycle; alu_done=1 -> WRITEBACK.
REQ-024 wait_cnt SHALL clear to 0 on every entry to MEM or ALU_WAIT, increment by 1 per cycle spent in those states, saturate at all-ones, and hold 0 in all other states.
REQ-025 With TIMEOUT!=0, a wait state SHALL go to FAULT when wait_cnt==TIMEOUT and the completion input is 0.
REQ-026 When completion and timeout occur in the same cycle, completion SHALL win and the FSM SHALL go to WRITEBACK.
REQ-027 WRITEBACK: pc_enable=1; reg_write=1 unless opcode==OP_STORE; -> FETCH.
REQ-028 HALT: halt=1; resume=0 -> stay in HALT; resume=1 -> pc_enable=1 this cycle and -> FETCH.
REQ-029 FAULT: fault=1; the FSM SHALL stay in FAULT, with all other strobes 0, until reset.
REQ-030 Instruction latency SHALL be 4 cycles for ALU ops, 5+N cycles for memory ops, and 5+N cycles for crypto ops, where N is wait cycles before completion.
REQ-031 mem_ready and alu_done SHALL be ignored outside MEM and ALU_WAIT respectively.
REQ-032 Unreachable encodings: none exist; a default case SHALL go to FETCH.

Reset
REQ-033 reset=1 SHALL asynchronously force state=FETCH and wait_cnt=0; every strobe SHALL then read 0.
REQ-034 Assertion of reset mid-MEM or mid-ALU_WAIT SHALL drop mem_read, mem_write and alu_enable in the same cycle, without waiting for a clock edge.
REQ-035 After reset is released, the first rising edge SHALL move FETCH -> DECODE.

Verification
REQ-036 opcode=0001 after reset: state 0,1,2,4,0; alu_enable in cycle 3; reg_write=pc_enable=1 in cycle 4.
REQ-037 OP_LOAD with mem_ready high on the 3rd MEM cycle: mem_read=1 for 3 cycles; wait_cnt 0,1,2; WRITEBACK has reg_write=1; total 7 cycles.
REQ-038 OP_STORE, TIMEOUT=4, mem_ready stuck at 0: mem_write=1 for 5 cycles, then state=7 and fault=1, held 20 cycles.
REQ-039 OP_CRYPTO, TIMEOUT=4, alu_done=1 when wait_cnt==4: state -> 4, not 7; alu_start pulses exactly once, in EXECUTE.
REQ-040 OP_HALT: halt=1 for 10 cycles; resume=1 for one cycle -> pc_enable=1 that cycle, then state=0.
REQ-041 reset asserted on 2nd MEM cycle between clock edges: state=0 and all strobes 0 immediately; normal FETCH -> DECODE after release.
